// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote button front end.
package vote_pkg;

    localparam int NUM_CAND = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PULSE        = 2'd1,
        WAIT_RELEASE = 2'd2,
        LOCKOUT      = 2'd3
    } state_t;

    typedef logic [1:0] cand_idx_t;

    function automatic logic [2:0] count_ones(input logic [NUM_CAND-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_CAND; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

    // Lowest set bit wins; only meaningful when v is one-hot.
    function automatic cand_idx_t first_index(input logic [NUM_CAND-1:0] v);
        cand_idx_t idx;
        idx = 2'd0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = cand_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-level debounce filter for one button.
module button_debounce
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    // Synchronise, then toggle the level once the new value has persisted long enough.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= {CW{1'b0}};
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_button};
            if (r_sync[1] != r_level) begin
                if (r_cnt == CNT_MAX) begin
                    r_level <= ~r_level;
                    r_cnt   <= {CW{1'b0}};
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= {CW{1'b0}};
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/vote_button_ctrl.sv
// Four debounced buttons -> single-cycle candidate vote pulses with lockout.
// Optional `VOTE_ACK_EN adds the vote_ack LED/buzzer output.
module vote_button_ctrl
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8
`ifdef VOTE_ACK_EN
    ,
    parameter int ACK_CYCLES      = 16
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic mode,
    input  logic button1,
    input  logic button2,
    input  logic button3,
    input  logic button4,
    output logic cand1_validvote,
    output logic cand2_validvote,
    output logic cand3_validvote,
    output logic cand4_validvote,
    output logic multi_press_err,
    output logic busy
`ifdef VOTE_ACK_EN
    ,
    output logic vote_ack
`endif
);

    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    logic [NUM_CAND-1:0] w_btn_raw;
    logic [NUM_CAND-1:0] w_db_level;
    logic [2:0]          w_ones;

    state_t              r_state, w_state_nxt;
    cand_idx_t           r_idx, w_idx_nxt;
    logic [LW-1:0]       r_lock_cnt, w_lock_nxt;
    logic [NUM_CAND-1:0] r_cand, w_cand_d;
    logic                r_err, w_err_d;
    logic                r_busy, w_busy_d;

    assign w_btn_raw = {button4, button3, button2, button1};

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .i_button (w_btn_raw[g]),
            .o_level  (w_db_level[g])
        );
    end

    assign w_ones = count_ones(w_db_level);

    // State, lockout counter, latched candidate and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_idx      <= 2'd0;
            r_lock_cnt <= {LW{1'b0}};
            r_cand     <= {NUM_CAND{1'b0}};
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_cand     <= w_cand_d;
            r_err      <= w_err_d;
            r_busy     <= w_busy_d;
        end
    end

    // Next-state logic: one vote per press, reject simultaneous presses.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_lock_nxt  = r_lock_cnt;
        case (r_state)
            IDLE: begin
                if (mode) begin
                    w_state_nxt = IDLE;
                end else if (w_ones == 3'd1) begin
                    w_state_nxt = PULSE;
                    w_idx_nxt   = first_index(w_db_level);
                end else if (w_ones >= 3'd2) begin
                    w_state_nxt = WAIT_RELEASE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PULSE: begin
                w_state_nxt = LOCKOUT;
                w_lock_nxt  = LOCK_LOAD;
            end
            LOCKOUT: begin
                if (r_lock_cnt == {LW{1'b0}}) begin
                    w_state_nxt = WAIT_RELEASE;
                end else begin
                    w_lock_nxt = r_lock_cnt - LW'(1);
                end
            end
            WAIT_RELEASE: begin
                if (w_db_level == {NUM_CAND{1'b0}}) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_RELEASE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        w_cand_d = {NUM_CAND{1'b0}};
        if (w_state_nxt == PULSE) begin
            w_cand_d[w_idx_nxt] = 1'b1;
        end else begin
            w_cand_d = {NUM_CAND{1'b0}};
        end
        w_err_d  = (r_state == IDLE) && (w_state_nxt == WAIT_RELEASE);
        w_busy_d = (w_state_nxt != IDLE);
    end

    assign cand1_validvote = r_cand[0];
    assign cand2_validvote = r_cand[1];
    assign cand3_validvote = r_cand[2];
    assign cand4_validvote = r_cand[3];
    assign multi_press_err = r_err;
    assign busy            = r_busy;

`ifdef VOTE_ACK_EN
    localparam int AW = $clog2(ACK_CYCLES + 1);
    localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_CYCLES - 1);

    logic          r_ack;
    logic [AW-1:0] r_ack_cnt;

    // Acknowledge stretch: starts the cycle after the pulse, restarts on a new pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ack     <= 1'b0;
            r_ack_cnt <= {AW{1'b0}};
        end else if (r_state == PULSE) begin
            r_ack     <= 1'b1;
            r_ack_cnt <= ACK_LOAD;
        end else if (r_ack) begin
            if (r_ack_cnt == {AW{1'b0}}) begin
                r_ack <= 1'b0;
            end else begin
                r_ack_cnt <= r_ack_cnt - AW'(1);
            end
        end else begin
            r_ack     <= 1'b0;
            r_ack_cnt <= r_ack_cnt;
        end
    end

    assign vote_ack = r_ack;
`endif

endmodule

// File: tb/tb_vote_button_ctrl.sv
// Directed bench for vote_button_ctrl (DEBOUNCE=4, LOCKOUT=8, ACK=16).
module tb_vote_button_ctrl;

    logic clk = 1'b0;
    logic rst, mode, b1, b2, b3, b4;
    logic c1, c2, c3, c4, err, busy;
`ifdef VOTE_ACK_EN
    logic ack;
`endif

    int total = 0;
    int bad   = 0;
    int n_pulse[4] = '{0, 0, 0, 0};
    int n_err  = 0;
    int n_busy = 0;

    always #5 clk = ~clk;

    vote_button_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .button1         (b1),
        .button2         (b2),
        .button3         (b3),
        .button4         (b4),
        .cand1_validvote (c1),
        .cand2_validvote (c2),
        .cand3_validvote (c3),
        .cand4_validvote (c4),
        .multi_press_err (err),
        .busy            (busy)
`ifdef VOTE_ACK_EN
        ,
        .vote_ack        (ack)
`endif
    );

    // Pulse/busy tally and output exclusivity, sampled on the falling edge.
    always @(negedge clk) begin
        total++;
        if ($countones({c4, c3, c2, c1, err}) > 1) begin
            bad++;
            $display("FAIL exclusivity: got %b%b%b%b err=%b required at most one high", c4, c3, c2, c1, err);
        end
        if (c1)   n_pulse[0]++;
        if (c2)   n_pulse[1]++;
        if (c3)   n_pulse[2]++;
        if (c4)   n_pulse[3]++;
        if (err)  n_err++;
        if (busy) n_busy++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] v);
        {b4, b3, b2, b1} = v;
    endtask

    typedef struct {
        logic        m1;
        logic [3:0]  bt1;
        int          n1;
        logic        m2;
        logic [3:0]  bt2;
        int          n2;
        logic [15:0] pc1;
        int          err1;
        logic [15:0] pc_tot;
        int          err_tot;
        logic        busy_never;
    } vec_t;

    vec_t tv[7];
    int   s_p[4];
    int   s_e, s_b, p;

    initial begin
        // pc fields: nibble 0 = cand1 ... nibble 3 = cand4
        tv[0] = '{1'b0, 4'b0001, 3,  1'b0, 4'b0000, 10, 16'h0000, 0, 16'h0000, 0, 1'b1};
        tv[1] = '{1'b0, 4'b1100, 20, 1'b0, 4'b0000, 5,  16'h0000, 1, 16'h0000, 1, 1'b0};
        tv[2] = '{1'b0, 4'b1000, 20, 1'b0, 4'b0000, 5,  16'h1000, 0, 16'h1000, 0, 1'b0};
        tv[3] = '{1'b1, 4'b0010, 20, 1'b0, 4'b0010, 20, 16'h0000, 0, 16'h0010, 0, 1'b0};
        tv[4] = '{1'b0, 4'b0001, 40, 1'b0, 4'b0001, 20, 16'h0001, 0, 16'h0001, 0, 1'b0};
        tv[5] = '{1'b0, 4'b0100, 20, 1'b0, 4'b0110, 20, 16'h0100, 0, 16'h0100, 0, 1'b0};
        tv[6] = '{1'b1, 4'b0011, 20, 1'b1, 4'b0000, 10, 16'h0000, 0, 16'h0000, 0, 1'b1};

        // Reset with button2 held, then exact first-pulse latency.
        rst = 1'b0; mode = 1'b0; set_btn(4'b0010);
        repeat (3) step();
        chk("reset_cands", int'({c4, c3, c2, c1}), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            chk($sformatf("lat_c2_e%0d", k), int'(c2), int'(k == 7));
            chk($sformatf("lat_busy_e%0d", k), int'(busy), int'(k >= 7));
        end
        p = n_pulse[1];
        repeat (30) step();
        chk("held_no_repeat", n_pulse[1] - p, 0);
        set_btn(4'b0000);
        repeat (25) step();
        chk("idle_after_release", int'(busy), 0);

        // Table of press scenarios.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 4; j++) s_p[j] = n_pulse[j];
            s_e = n_err;
            s_b = n_busy;
            mode = tv[i].m1; set_btn(tv[i].bt1);
            repeat (tv[i].n1) step();
            for (int j = 0; j < 4; j++)
                chk($sformatf("tv%0d_p1_c%0d", i, j + 1), n_pulse[j] - s_p[j], int'(tv[i].pc1[j*4 +: 4]));
            chk($sformatf("tv%0d_p1_err", i), n_err - s_e, tv[i].err1);
            mode = tv[i].m2; set_btn(tv[i].bt2);
            repeat (tv[i].n2) step();
            mode = 1'b0; set_btn(4'b0000);
            repeat (25) step();
            for (int j = 0; j < 4; j++)
                chk($sformatf("tv%0d_tot_c%0d", i, j + 1), n_pulse[j] - s_p[j], int'(tv[i].pc_tot[j*4 +: 4]));
            chk($sformatf("tv%0d_tot_err", i), n_err - s_e, tv[i].err_tot);
            chk($sformatf("tv%0d_end_busy", i), int'(busy), 0);
            if (tv[i].busy_never) chk($sformatf("tv%0d_busy_never", i), n_busy - s_b, 0);
        end

        // Exact lockout length: 8-cycle press of button3.
        set_btn(4'b0100);
        for (int k = 0; k <= 18; k++) begin
            step();
            chk($sformatf("lock_c3_e%0d", k), int'(c3), int'(k == 7));
            chk($sformatf("lock_busy_e%0d", k), int'(busy), int'(k >= 7 && k <= 16));
            if (k == 7) set_btn(4'b0000);
        end
        repeat (10) step();

        // Bounce inside lockout, then a genuine second press.
        p = n_pulse[0];
        b1 = 1'b1; repeat (10) step();
        b1 = 1'b0; repeat (2) step();
        b1 = 1'b1; repeat (30) step();
        chk("bounce_one_vote", n_pulse[0] - p, 1);
        b1 = 1'b0; repeat (25) step();
        b1 = 1'b1; repeat (20) step();
        chk("second_press_vote", n_pulse[0] - p, 2);
        b1 = 1'b0; repeat (25) step();

        // Reset during the pulse cycle aborts everything.
        p = n_pulse[3];
        b4 = 1'b1;
        repeat (8) step();
        chk("pre_reset_c4", int'(c4), 1);
        rst = 1'b0; b4 = 1'b0;
        step();
        chk("midpulse_rst_cands", int'({c4, c3, c2, c1}), 0);
        chk("midpulse_rst_busy", int'(busy), 0);
        step();
        rst = 1'b1;
        repeat (25) step();
        chk("midpulse_rst_total", n_pulse[3] - p, 1);

`ifdef VOTE_ACK_EN
        // Acknowledge: 16 cycles from the cycle after the pulse.
        b1 = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            step();
            chk($sformatf("ack_e%0d", k), int'(ack), int'(k >= 8 && k <= 23));
        end
        b1 = 1'b0; repeat (30) step();
        b1 = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            chk($sformatf("ack2_e%0d", k), int'(ack), int'(k >= 8));
        end
        rst = 1'b0; b1 = 1'b0;
        step();
        chk("ack_reset", int'(ack), 0);
        step();
        rst = 1'b1;
        repeat (10) step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
